// File: rtl/bsearch_probe_ctrl_pkg.sv
// Shared state encodings and default sizing for the binary-search probe controller.
package bsearch_probe_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PROBE = 2'd1,
      S_DONE  = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 4;
   // A search takes at most WIDTH+1 probes, so the counter must represent WIDTH+1.
   localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 2);

endpackage

// File: rtl/bsearch_probe_ctrl.sv
// Binary-search initiator: presents guesses to a magnitude comparator and narrows
// [lo, hi] on its greater/equal/less flags until it hits, or flags an inconsistency.
module bsearch_probe_ctrl
   import bsearch_probe_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] guess,
   output logic             guess_vld,
   input  logic             cmp_g,
   input  logic             cmp_e,
   input  logic             cmp_l,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] probe_cnt
);

   localparam logic [WIDTH-1:0] MAXV = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_n;
   logic [WIDTH-1:0] lo, hi, lo_n, hi_n, result_n;
   logic [CNT_W-1:0] cnt_n;
   logic [WIDTH:0]   sum;

   // Midpoint summed one bit wider so lo+hi cannot wrap.
   assign sum       = {1'b0, lo} + {1'b0, hi};
   assign guess     = sum[WIDTH:1];
   assign busy      = (state == S_PROBE);
   assign guess_vld = busy;
   assign done      = (state == S_DONE) || (state == S_ERR);
   assign err       = (state == S_ERR);

   always_comb begin
      state_n  = state;
      lo_n     = lo;
      hi_n     = hi;
      result_n = result;
      cnt_n    = probe_cnt;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               lo_n    = '0;
               hi_n    = MAXV;
               cnt_n   = '0;
               state_n = S_PROBE;
            end
         end
         S_PROBE: begin
            cnt_n = (probe_cnt == CNT_MAX) ? probe_cnt : probe_cnt + CNT_W'(1);
            case ({cmp_g, cmp_e, cmp_l})
               3'b010: begin
                  result_n = guess;
                  state_n  = S_DONE;
               end
               3'b100: begin
                  // Boundary checked first so guess+1 never wraps.
                  if (guess == MAXV) begin
                     state_n = S_ERR;
                  end else begin
                     lo_n = guess + WIDTH'(1);
                     if (lo_n > hi) state_n = S_ERR;
                  end
               end
               3'b001: begin
                  if (guess == '0) begin
                     state_n = S_ERR;
                  end else begin
                     hi_n = guess - WIDTH'(1);
                     if (lo > hi_n) state_n = S_ERR;
                  end
               end
               default: state_n = S_ERR;
            endcase
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         lo        <= '0;
         hi        <= '0;
         result    <= '0;
         probe_cnt <= '0;
      end else begin
         state     <= state_n;
         lo        <= lo_n;
         hi        <= hi_n;
         result    <= result_n;
         probe_cnt <= cnt_n;
      end
   end

endmodule

// File: tb/tb_bsearch_probe_ctrl.sv
// Directed bench for bsearch_probe_ctrl with a behavioural 4-bit magnitude comparator as responder.
module tb_bsearch_probe_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] guess;
   logic       guess_vld;
   logic       cmp_g, cmp_e, cmp_l;
   logic       busy, done, err;
   logic [3:0] result;
   logic [2:0] probe_cnt;

   logic [3:0] target = 4'd0;
   logic       force_en = 1'b0;
   logic [2:0] force_flags = 3'b000;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Responder: a = target, b = guess; flags can be overridden for bad-response cases.
   assign {cmp_g, cmp_e, cmp_l} = force_en ? force_flags
                                           : {target > guess, target == guess, target < guess};

   bsearch_probe_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .guess(guess), .guess_vld(guess_vld),
      .cmp_g(cmp_g), .cmp_e(cmp_e), .cmp_l(cmp_l),
      .busy(busy), .done(done), .err(err),
      .result(result), .probe_cnt(probe_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({busy, done, err, guess_vld} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags busy/done/err/vld=%b required 0000", {busy, done, err, guess_vld});
      end
      checks++;
      if ({guess, result, probe_cnt} !== 11'd0) begin
         errors++;
         $display("FAIL reset_values guess=%0d result=%0d cnt=%0d required 0 0 0", guess, result, probe_cnt);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_target7();
      target = 4'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if ({guess, busy, guess_vld, done} !== {4'd7, 3'b110}) begin
         errors++;
         $display("FAIL t7_probe guess=%0d busy=%b vld=%b done=%b required 7 1 1 0", guess, busy, guess_vld, done);
      end
      step();
      checks++;
      if ({done, err, busy, result, probe_cnt} !== {3'b100, 4'd7, 3'd1}) begin
         errors++;
         $display("FAIL t7_done done=%b err=%b busy=%b result=%0d cnt=%0d required 1 0 0 7 1",
                  done, err, busy, result, probe_cnt);
      end
   endtask

   task automatic test_target15();
      logic [3:0] exp_g [5] = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
      target = 4'd15;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL t15_done_clear done=%b required 0", done);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (guess !== exp_g[i] || busy !== 1'b1) begin
            errors++;
            $display("FAIL t15_guess%0d guess=%0d busy=%b required %0d 1", i, guess, busy, exp_g[i]);
         end
         step();
      end
      checks++;
      if ({done, err, result, probe_cnt} !== {2'b10, 4'd15, 3'd5}) begin
         errors++;
         $display("FAIL t15_done done=%b err=%b result=%0d cnt=%0d required 1 0 15 5", done, err, result, probe_cnt);
      end
   endtask

   task automatic test_target0();
      logic [3:0] exp_g [4] = '{4'd7, 4'd3, 4'd1, 4'd0};
      target = 4'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (guess !== exp_g[i]) begin
            errors++;
            $display("FAIL t0_guess%0d guess=%0d required %0d", i, guess, exp_g[i]);
         end
         step();
      end
      checks++;
      if ({done, err, result, probe_cnt} !== {2'b10, 4'd0, 3'd4}) begin
         errors++;
         $display("FAIL t0_done done=%b err=%b result=%0d cnt=%0d required 1 0 0 4", done, err, result, probe_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int exp_cnt [16] = '{4, 3, 4, 2, 4, 3, 4, 1, 4, 3, 4, 2, 4, 3, 4, 5};
      int n;
      for (int t = 0; t < 16; t++) begin
         target = 4'(t);
         start = 1'b1;
         step();
         start = 1'b0;
         n = 0;
         while (done !== 1'b1 && n < 10) begin
            step();
            n++;
         end
         checks++;
         if (n >= 10) begin
            errors++;
            $display("FAIL sweep_timeout target=%0d done=%b required 1 within 10 cycles", t, done);
         end else if (result !== 4'(t) || err !== 1'b0 || int'(probe_cnt) != exp_cnt[t] || n != exp_cnt[t]) begin
            errors++;
            $display("FAIL sweep target=%0d result=%0d err=%b cnt=%0d cycles=%0d required %0d 0 %0d %0d",
                     t, result, err, probe_cnt, n, t, exp_cnt[t], exp_cnt[t]);
         end
      end
   endtask

   task automatic test_bad_flags();
      // Previous search ended with result 15; error paths must leave it alone.
      force_en = 1'b1;
      force_flags = 3'b000;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      checks++;
      if ({done, err, busy, probe_cnt, result} !== {3'b110, 3'd1, 4'd15}) begin
         errors++;
         $display("FAIL bad_000 done=%b err=%b busy=%b cnt=%0d result=%0d required 1 1 0 1 15",
                  done, err, busy, probe_cnt, result);
      end

      force_flags = 3'b001;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if ({done, err} !== 2'b00) begin
         errors++;
         $display("FAIL bad_restart done=%b err=%b required 0 0", done, err);
      end
      for (int i = 0; i < 4; i++) step();
      checks++;
      if ({done, err, probe_cnt, result} !== {2'b11, 3'd4, 4'd15}) begin
         errors++;
         $display("FAIL bad_l_at_0 done=%b err=%b cnt=%0d result=%0d required 1 1 4 15", done, err, probe_cnt, result);
      end

      force_flags = 3'b110;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      checks++;
      if ({done, err, probe_cnt} !== {2'b11, 3'd1}) begin
         errors++;
         $display("FAIL bad_110 done=%b err=%b cnt=%0d required 1 1 1", done, err, probe_cnt);
      end
      force_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp_g [5] = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
      target = 4'd15;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      checks++;
      if (guess !== 4'd13) begin
         errors++;
         $display("FAIL mid_third_probe guess=%0d required 13", guess);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if ({busy, done, err, guess, probe_cnt} !== {3'b000, 4'd0, 3'd0}) begin
         errors++;
         $display("FAIL mid_reset busy=%b done=%b err=%b guess=%0d cnt=%0d required 0 0 0 0 0",
                  busy, done, err, guess, probe_cnt);
      end
      start = 1'b1;
      step();
      // start stays high through the first three probes and must be ignored.
      for (int i = 0; i < 5; i++) begin
         if (i == 3) start = 1'b0;
         checks++;
         if (guess !== exp_g[i] || busy !== 1'b1 || int'(probe_cnt) != i) begin
            errors++;
            $display("FAIL mid_rerun%0d guess=%0d busy=%b cnt=%0d required %0d 1 %0d",
                     i, guess, busy, probe_cnt, exp_g[i], i);
         end
         step();
      end
      checks++;
      if ({done, err, result, probe_cnt} !== {2'b10, 4'd15, 3'd5}) begin
         errors++;
         $display("FAIL mid_done done=%b err=%b result=%0d cnt=%0d required 1 0 15 5", done, err, result, probe_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_target7();
      test_target15();
      test_target0();
      test_back_to_back();
      test_bad_flags();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
